// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the fetch-stage handshake and data signals.
//   master: the fetch stage (drives imem request and the if_* head outputs)
//   slave : the environment (instruction memory, execute redirect, decode ready)
interface fetch_stage_if #(
   parameter int XLEN = 32
);
   // instruction-memory request/response
   logic            imem_req_valid;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rdata;
   // branch/jump redirect from execute
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   // hand-off to decode
   logic            id_ready;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;

   modport master (
      output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
      input  imem_rsp_valid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
      output imem_rsp_valid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch front end; PC, sequential imem requests, small head buffer.
// Latency: request issued in C0, response in C1, instruction on if_* in C2; redirect at R shows target at R+3.
// Backpressure: id_ready=0 freezes the head; requests stop once buffered + in-flight words reach BUF_DEPTH.
//
// Ports:
//   clk_i    - clock, all state updates on posedge
//   reset_i  - synchronous active-low reset
//   bus      - fetch_stage_if.master: imem req/rsp, redirect, decode handshake
module fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   fetch_stage_if.master bus
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            inflight_q, inflight_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            kill_q, kill_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [XLEN-1:0] buf_pc_q    [BUF_DEPTH];
   logic [31:0]     buf_instr_q [BUF_DEPTH];

   logic            not_empty;
   logic            deq;
   logic            enq;
   logic            issue;
   logic [CW:0]     credit_used;

   // Only word-aligned targets are fetched; the low redirect bits are dropped.
   logic            unused_redirect_lsb;
   assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

   // Outputs are forced quiet while reset is asserted, not only after it.
   assign not_empty = reset_i && (count_q != '0);
   assign deq       = not_empty && bus.id_ready;

   // Credits: a word already buffered or still in flight occupies a slot,
   // a word leaving to decode this cycle frees one.
   assign credit_used = {1'b0, count_q}
                      + {{CW{1'b0}}, inflight_q}
                      - {{CW{1'b0}}, deq};
   assign issue = reset_i && !bus.redirect_valid && (credit_used < DEPTH_C);

   // A response is kept only if it belongs to a live request and is not
   // being flushed by a redirect in the same cycle.
   assign enq = bus.imem_rsp_valid && inflight_q && !kill_q && !bus.redirect_valid;

   assign bus.imem_req_valid = issue;
   assign bus.imem_addr      = pc_q;
   assign bus.if_valid       = not_empty;
   assign bus.if_pc          = not_empty ? buf_pc_q[rd_ptr_q]    : '0;
   assign bus.if_instr       = not_empty ? buf_instr_q[rd_ptr_q] : '0;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      kill_d        = kill_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (bus.redirect_valid) begin
         // Flush wins over enqueue; an outstanding response gets killed.
         pc_d     = {bus.redirect_pc[XLEN-1:2], 2'b00};
         kill_d   = inflight_q;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (issue) begin
            pc_d          = pc_q + XLEN'(4);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            kill_d        = 1'b0;
         end
         if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         kill_q        <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         kill_q        <= kill_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // Buffer storage needs no reset: count gates visibility of every entry.
   always_ff @(posedge clk_i) begin
      if (reset_i && enq) begin
         buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
         buf_instr_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   // The credit rule guarantees room for every accepted response.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_i)
      enq |-> (count_q < CW'(BUF_DEPTH)));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic inject = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fetch_stage_if #(.XLEN(XLEN)) bus ();

   fetch_stage #(
      .XLEN      (XLEN),
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   // mem[i] = 32'h1000 + i, i = word index
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'h1000 + {2'b00, a[31:2]};
   endfunction

   // 1-cycle instruction memory; 'inject' forces a stray response next cycle.
   initial begin
      logic        r;
      logic        inj;
      logic [31:0] a;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rdata     = '0;
      forever begin
         @(posedge clk);
         r   = bus.imem_req_valid;
         a   = bus.imem_addr;
         inj = inject;
         #1;
         bus.imem_rsp_valid = r | inj;
         bus.imem_rdata     = inj ? 32'hDEAD_BEEF : word_at(a);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic start_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the start of C0 (first cycle with reset released).
   task automatic do_reset();
      reset              = 1'b0;
      inject             = 1'b0;
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      repeat (3) start_cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset              = 1'b0;
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      repeat (2) start_cycle();
      @(negedge clk);
      if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset req_valid: got %b want 0", bus.imem_req_valid); end
      checks++;
      if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset if_valid: got %b want 0", bus.if_valid); end
      checks++;
      if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset if_pc: got %h want 0", bus.if_pc); end
      checks++;
      if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset if_instr: got %h want 0", bus.if_instr); end
      checks++;
      start_cycle();
   endtask

   task automatic test_stream();
      logic        e_req, e_vld;
      logic [31:0] e_addr, e_pc, e_instr;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         e_req   = 1'b1;
         e_addr  = 32'(4 * k);
         e_vld   = (k >= 2);
         e_pc    = e_vld ? 32'(4 * (k - 2)) : 32'h0;
         e_instr = e_vld ? 32'h1000 + (e_pc >> 2) : 32'h0;
         @(negedge clk);
         if (bus.imem_req_valid !== e_req) begin errors++; $display("FAIL stream req_valid c%0d: got %b want %b", k, bus.imem_req_valid, e_req); end
         checks++;
         if (bus.imem_addr !== e_addr) begin errors++; $display("FAIL stream addr c%0d: got %h want %h", k, bus.imem_addr, e_addr); end
         checks++;
         if (bus.if_valid !== e_vld) begin errors++; $display("FAIL stream if_valid c%0d: got %b want %b", k, bus.if_valid, e_vld); end
         checks++;
         if (bus.if_pc !== e_pc) begin errors++; $display("FAIL stream if_pc c%0d: got %h want %h", k, bus.if_pc, e_pc); end
         checks++;
         if (bus.if_instr !== e_instr) begin errors++; $display("FAIL stream if_instr c%0d: got %h want %h", k, bus.if_instr, e_instr); end
         checks++;
         start_cycle();
      end
   endtask

   task automatic test_stall();
      logic        e_req, e_vld;
      logic [31:0] e_addr, e_pc, e_instr;
      do_reset();
      for (int k = 0; k < 13; k++) begin
         bus.id_ready = !(k >= 4 && k <= 8);
         e_req  = !(k >= 4 && k <= 8);
         e_addr = (k < 4) ? 32'(4 * k) : 32'h10 + 32'(4 * (k - 9));
         e_vld  = (k >= 2);
         if (!e_vld)      e_pc = 32'h0;
         else if (k <= 4) e_pc = 32'(4 * (k - 2));
         else if (k <= 9) e_pc = 32'h8;
         else             e_pc = 32'hC + 32'(4 * (k - 10));
         e_instr = e_vld ? 32'h1000 + (e_pc >> 2) : 32'h0;
         @(negedge clk);
         if (bus.imem_req_valid !== e_req) begin errors++; $display("FAIL stall req_valid c%0d: got %b want %b", k, bus.imem_req_valid, e_req); end
         checks++;
         if (e_req) begin
            if (bus.imem_addr !== e_addr) begin errors++; $display("FAIL stall addr c%0d: got %h want %h", k, bus.imem_addr, e_addr); end
            checks++;
         end
         if (bus.if_valid !== e_vld) begin errors++; $display("FAIL stall if_valid c%0d: got %b want %b", k, bus.if_valid, e_vld); end
         checks++;
         if (bus.if_pc !== e_pc) begin errors++; $display("FAIL stall if_pc c%0d: got %h want %h", k, bus.if_pc, e_pc); end
         checks++;
         if (bus.if_instr !== e_instr) begin errors++; $display("FAIL stall if_instr c%0d: got %h want %h", k, bus.if_instr, e_instr); end
         checks++;
         start_cycle();
      end
      bus.id_ready = 1'b1;
   endtask

   // Redirect to 0x40 in C5 while the 0x10 fetch is in flight.
   task automatic test_redirect();
      logic        e_req, e_vld;
      logic [31:0] e_addr, e_pc, e_instr;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         bus.redirect_valid = (k == 5);
         bus.redirect_pc    = 32'h40;
         e_req  = (k != 5);
         e_addr = (k < 5) ? 32'(4 * k) : 32'h40 + 32'(4 * (k - 6));
         e_vld  = (k >= 2 && k <= 5) || (k >= 8);
         if (!e_vld)      e_pc = 32'h0;
         else if (k <= 5) e_pc = 32'(4 * (k - 2));
         else             e_pc = 32'h40 + 32'(4 * (k - 8));
         e_instr = e_vld ? 32'h1000 + (e_pc >> 2) : 32'h0;
         @(negedge clk);
         if (bus.imem_req_valid !== e_req) begin errors++; $display("FAIL redirect req_valid c%0d: got %b want %b", k, bus.imem_req_valid, e_req); end
         checks++;
         if (e_req) begin
            if (bus.imem_addr !== e_addr) begin errors++; $display("FAIL redirect addr c%0d: got %h want %h", k, bus.imem_addr, e_addr); end
            checks++;
         end
         if (bus.if_valid !== e_vld) begin errors++; $display("FAIL redirect if_valid c%0d: got %b want %b", k, bus.if_valid, e_vld); end
         checks++;
         if (bus.if_pc !== e_pc) begin errors++; $display("FAIL redirect if_pc c%0d: got %h want %h", k, bus.if_pc, e_pc); end
         checks++;
         if (bus.if_instr !== e_instr) begin errors++; $display("FAIL redirect if_instr c%0d: got %h want %h", k, bus.if_instr, e_instr); end
         checks++;
         start_cycle();
      end
      bus.redirect_valid = 1'b0;
   endtask

   // Unaligned redirect 0x43 in C3, then back-to-back redirects 0x80/0xC0 in C8/C9.
   task automatic test_back_to_back();
      logic        e_req, e_vld;
      logic [31:0] e_addr, e_pc, e_instr;
      do_reset();
      for (int k = 0; k < 14; k++) begin
         bus.redirect_valid = (k == 3) || (k == 8) || (k == 9);
         bus.redirect_pc    = (k == 3) ? 32'h43 : ((k == 8) ? 32'h80 : 32'hC0);
         e_req = !((k == 3) || (k == 8) || (k == 9));
         if (k < 3)       e_addr = 32'(4 * k);
         else if (k < 8)  e_addr = 32'h40 + 32'(4 * (k - 4));
         else             e_addr = 32'hC0 + 32'(4 * (k - 10));
         e_vld = (k == 2) || (k == 3) || (k >= 6 && k <= 8) || (k >= 12);
         if (!e_vld)      e_pc = 32'h0;
         else if (k <= 3) e_pc = 32'(4 * (k - 2));
         else if (k <= 8) e_pc = 32'h40 + 32'(4 * (k - 6));
         else             e_pc = 32'hC0 + 32'(4 * (k - 12));
         e_instr = e_vld ? 32'h1000 + (e_pc >> 2) : 32'h0;
         @(negedge clk);
         if (bus.imem_req_valid !== e_req) begin errors++; $display("FAIL b2b req_valid c%0d: got %b want %b", k, bus.imem_req_valid, e_req); end
         checks++;
         if (e_req) begin
            if (bus.imem_addr !== e_addr) begin errors++; $display("FAIL b2b addr c%0d: got %h want %h", k, bus.imem_addr, e_addr); end
            checks++;
         end
         if (bus.if_valid !== e_vld) begin errors++; $display("FAIL b2b if_valid c%0d: got %b want %b", k, bus.if_valid, e_vld); end
         checks++;
         if (bus.if_pc !== e_pc) begin errors++; $display("FAIL b2b if_pc c%0d: got %h want %h", k, bus.if_pc, e_pc); end
         checks++;
         if (bus.if_instr !== e_instr) begin errors++; $display("FAIL b2b if_instr c%0d: got %h want %h", k, bus.if_instr, e_instr); end
         checks++;
         start_cycle();
      end
      bus.redirect_valid = 1'b0;
   endtask

   // Redirect to the top word in C2; the next sequential address wraps to 0.
   task automatic test_wrap();
      logic        e_req, e_vld;
      logic [31:0] e_addr, e_pc, e_instr;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         bus.redirect_valid = (k == 2);
         bus.redirect_pc    = 32'hFFFF_FFFC;
         e_req  = (k != 2);
         e_addr = (k < 2) ? 32'(4 * k) : 32'hFFFF_FFFC + 32'(4 * (k - 3));
         e_vld  = (k == 2) || (k >= 5);
         if (!e_vld)       e_pc = 32'h0;
         else if (k == 2)  e_pc = 32'h0;
         else              e_pc = 32'hFFFF_FFFC + 32'(4 * (k - 5));
         e_instr = e_vld ? 32'h1000 + (e_pc >> 2) : 32'h0;
         @(negedge clk);
         if (bus.imem_req_valid !== e_req) begin errors++; $display("FAIL wrap req_valid c%0d: got %b want %b", k, bus.imem_req_valid, e_req); end
         checks++;
         if (e_req) begin
            if (bus.imem_addr !== e_addr) begin errors++; $display("FAIL wrap addr c%0d: got %h want %h", k, bus.imem_addr, e_addr); end
            checks++;
         end
         if (bus.if_valid !== e_vld) begin errors++; $display("FAIL wrap if_valid c%0d: got %b want %b", k, bus.if_valid, e_vld); end
         checks++;
         if (bus.if_pc !== e_pc) begin errors++; $display("FAIL wrap if_pc c%0d: got %h want %h", k, bus.if_pc, e_pc); end
         checks++;
         if (bus.if_instr !== e_instr) begin errors++; $display("FAIL wrap if_instr c%0d: got %h want %h", k, bus.if_instr, e_instr); end
         checks++;
         start_cycle();
      end
      bus.redirect_valid = 1'b0;
   endtask

   // Fill the buffer with id_ready=0, pulse reset in C3, and inject a stray
   // response in C4 (first cycle after reset) that must be ignored.
   task automatic test_reset_mid();
      logic        e_req, e_vld;
      logic [31:0] e_addr, e_pc, e_instr;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         bus.id_ready = !((k == 2) || (k == 3));
         reset        = (k != 3);
         inject       = (k == 3);
         e_req  = !((k == 2) || (k == 3));
         e_addr = (k < 2) ? 32'(4 * k) : 32'(4 * (k - 4));
         e_vld  = (k == 2) || (k >= 6);
         if (!e_vld)      e_pc = 32'h0;
         else if (k == 2) e_pc = 32'h0;
         else             e_pc = 32'(4 * (k - 6));
         e_instr = e_vld ? 32'h1000 + (e_pc >> 2) : 32'h0;
         @(negedge clk);
         if (bus.imem_req_valid !== e_req) begin errors++; $display("FAIL rstmid req_valid c%0d: got %b want %b", k, bus.imem_req_valid, e_req); end
         checks++;
         if (e_req) begin
            if (bus.imem_addr !== e_addr) begin errors++; $display("FAIL rstmid addr c%0d: got %h want %h", k, bus.imem_addr, e_addr); end
            checks++;
         end
         if (bus.if_valid !== e_vld) begin errors++; $display("FAIL rstmid if_valid c%0d: got %b want %b", k, bus.if_valid, e_vld); end
         checks++;
         if (bus.if_pc !== e_pc) begin errors++; $display("FAIL rstmid if_pc c%0d: got %h want %h", k, bus.if_pc, e_pc); end
         checks++;
         if (bus.if_instr !== e_instr) begin errors++; $display("FAIL rstmid if_instr c%0d: got %h want %h", k, bus.if_instr, e_instr); end
         checks++;
         start_cycle();
      end
      reset        = 1'b1;
      inject       = 1'b0;
      bus.id_ready = 1'b1;
   endtask

   initial begin
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
